// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with saturating direction counters,
// optional gshare indexing, combinational lookup/resolution and branch statistics.
module branch_predictor #(
  parameter int WORD_SIZE    = 16,
  parameter int INDEX_BITS   = 6,
  parameter int COUNTER_BITS = 2,
  parameter int HIST_BITS    = 4,
  parameter int MODE         = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WORD_SIZE-1:0]  lookup_pc,
  output logic [WORD_SIZE-1:0]  pred_next_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_index,
  input  logic                  update_valid,
  input  logic [WORD_SIZE-1:0]  update_pc,
  input  logic [INDEX_BITS-1:0] update_index,
  input  logic                  update_taken,
  input  logic [WORD_SIZE-1:0]  update_target,
  input  logic [WORD_SIZE-1:0]  update_pred_next,
  output logic                  mispredict,
  output logic [WORD_SIZE-1:0]  correct_pc,
  output logic [WORD_SIZE-1:0]  num_branch,
  output logic [WORD_SIZE-1:0]  num_branch_miss
);
  localparam int DEPTH    = 1 << INDEX_BITS;
  localparam int TAG_BITS = WORD_SIZE - INDEX_BITS;
  localparam logic [COUNTER_BITS-1:0] CTR_MAX     = {COUNTER_BITS{1'b1}};
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK_T  = COUNTER_BITS'(1 << (COUNTER_BITS - 1));
  localparam logic [COUNTER_BITS-1:0] CTR_WEAK_NT = COUNTER_BITS'((1 << (COUNTER_BITS - 1)) - 1);

  logic                    r_valid  [DEPTH];
  logic [TAG_BITS-1:0]     r_tag    [DEPTH];
  logic [WORD_SIZE-1:0]    r_target [DEPTH];
  logic [COUNTER_BITS-1:0] r_ctr    [DEPTH];
  logic [HIST_BITS-1:0]    r_ghr;
  logic [WORD_SIZE-1:0]    r_num_branch;
  logic [WORD_SIZE-1:0]    r_num_miss;

  logic [INDEX_BITS-1:0]   w_idx;
  logic [TAG_BITS-1:0]     w_tag;
  logic                    w_hit;
  logic                    w_pred_taken;
  logic [WORD_SIZE-1:0]    w_actual_next;
  logic                    w_mispredict;
  logic [TAG_BITS-1:0]     w_upd_tag;
  logic                    w_upd_hit;
  logic [COUNTER_BITS-1:0] w_ctr_next;
  logic [HIST_BITS-1:0]    w_ghr_next;

  // Lookup path: reads pre-update contents, so a same-cycle update is not bypassed.
  assign w_tag = lookup_pc[WORD_SIZE-1:INDEX_BITS];
  assign w_idx = (MODE == 3) ? (lookup_pc[INDEX_BITS-1:0] ^ INDEX_BITS'(r_ghr))
                             : lookup_pc[INDEX_BITS-1:0];
  assign w_hit = r_valid[w_idx] && (r_tag[w_idx] == w_tag);

  always_comb begin
    case (MODE)
      1:       w_pred_taken = w_hit;
      2, 3:    w_pred_taken = w_hit && r_ctr[w_idx][COUNTER_BITS-1];
      default: w_pred_taken = 1'b0;
    endcase
  end

  assign pred_taken   = w_pred_taken;
  assign pred_next_pc = w_pred_taken ? r_target[w_idx] : lookup_pc + WORD_SIZE'(1);
  assign pred_index   = w_idx;

  assign w_actual_next = update_taken ? update_target : update_pc + WORD_SIZE'(1);
  assign w_mispredict  = update_valid && (w_actual_next != update_pred_next);
  assign mispredict    = w_mispredict;
  assign correct_pc    = w_actual_next;

  assign w_upd_tag = update_pc[WORD_SIZE-1:INDEX_BITS];
  assign w_upd_hit = r_valid[update_index] && (r_tag[update_index] == w_upd_tag);

  // A taken branch that misses the entry re-allocates it as weakly taken.
  always_comb begin
    w_ctr_next = r_ctr[update_index];
    if (update_taken) begin
      if (!w_upd_hit)
        w_ctr_next = CTR_WEAK_T;
      else if (r_ctr[update_index] != CTR_MAX)
        w_ctr_next = r_ctr[update_index] + COUNTER_BITS'(1);
    end else if (w_upd_hit && (r_ctr[update_index] != '0)) begin
      w_ctr_next = r_ctr[update_index] - COUNTER_BITS'(1);
    end
  end

  generate
    if (HIST_BITS > 1) begin : g_ghr_shift
      assign w_ghr_next = {r_ghr[HIST_BITS-2:0], update_taken};
    end else begin : g_ghr_bit
      assign w_ghr_next = update_taken;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= CTR_WEAK_NT;
      end
      r_ghr        <= '0;
      r_num_branch <= '0;
      r_num_miss   <= '0;
    end else if (update_valid) begin
      r_valid[update_index] <= r_valid[update_index] | update_taken;
      r_ctr[update_index]   <= w_ctr_next;
      r_ghr                 <= w_ghr_next;
      if (r_num_branch != '1)
        r_num_branch <= r_num_branch + WORD_SIZE'(1);
      if (w_mispredict && (r_num_miss != '1))
        r_num_miss <= r_num_miss + WORD_SIZE'(1);
    end
  end

  // Tags and targets carry no reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (!reset && update_valid && update_taken) begin
      r_tag[update_index]    <= w_upd_tag;
      r_target[update_index] <= update_target;
    end
  end

  assign num_branch      = r_num_branch;
  assign num_branch_miss = r_num_miss;
endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: MODE 2 and MODE 3 instances driven in lockstep and
// compared against an integer-level BTB model, with directed and random stimulus.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] lookup_pc;
  logic        update_valid;
  logic [15:0] update_pc;
  logic        update_taken;
  logic [15:0] update_target;
  logic [5:0]  upd_idx2, upd_idx3;
  logic [15:0] upd_pn2, upd_pn3;

  logic [15:0] pn2_o, pn3_o, cp2, cp3, nb2, nb3, nm2, nm3;
  logic        pt2, pt3, mp2, mp3;
  logic [5:0]  pi2, pi3;

  int n_tests = 0;
  int n_fail  = 0;

  int m_valid [2][64];
  int m_tag   [2][64];
  int m_tgt   [2][64];
  int m_ctr   [2][64];
  int m_ghr   [2];
  int m_nb    [2];
  int m_nm    [2];

  logic [15:0] s_next [2];
  int          s_idx  [2];

  always #5 clk = ~clk;

  branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .COUNTER_BITS(2), .HIST_BITS(4), .MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_next_pc(pn2_o), .pred_taken(pt2),
    .pred_index(pi2), .update_valid(update_valid), .update_pc(update_pc), .update_index(upd_idx2),
    .update_taken(update_taken), .update_target(update_target), .update_pred_next(upd_pn2),
    .mispredict(mp2), .correct_pc(cp2), .num_branch(nb2), .num_branch_miss(nm2)
  );

  branch_predictor #(.WORD_SIZE(16), .INDEX_BITS(6), .COUNTER_BITS(2), .HIST_BITS(4), .MODE(3)) u_dut3 (
    .clk(clk), .reset(reset), .lookup_pc(lookup_pc), .pred_next_pc(pn3_o), .pred_taken(pt3),
    .pred_index(pi3), .update_valid(update_valid), .update_pc(update_pc), .update_index(upd_idx3),
    .update_taken(update_taken), .update_target(update_target), .update_pred_next(upd_pn3),
    .mispredict(mp3), .correct_pc(cp3), .num_branch(nb3), .num_branch_miss(nm3)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: k = 0 is the MODE 2 predictor, k = 1 the gshare (MODE 3) predictor.
  function automatic int m_idx(input int k, input int pc);
    return (k == 1) ? ((pc % 64) ^ m_ghr[k]) : (pc % 64);
  endfunction

  function automatic int m_taken(input int k, input int pc);
    int i = m_idx(k, pc);
    return (m_valid[k][i] != 0 && m_tag[k][i] == pc / 64 && m_ctr[k][i] >= 2) ? 1 : 0;
  endfunction

  function automatic int m_pnext(input int k, input int pc);
    return (m_taken(k, pc) != 0) ? m_tgt[k][m_idx(k, pc)] : (pc + 1) % 65536;
  endfunction

  task automatic m_reset(input int k);
    for (int i = 0; i < 64; i++) begin
      m_valid[k][i] = 0;
      m_ctr[k][i]   = 1;
    end
    m_ghr[k] = 0;
    m_nb[k]  = 0;
    m_nm[k]  = 0;
  endtask

  task automatic m_update(input int k, input int idx, input int pc, input int taken, input int tgt, input int pn);
    int actual = (taken != 0) ? tgt : (pc + 1) % 65536;
    int hit    = (m_valid[k][idx] != 0 && m_tag[k][idx] == pc / 64) ? 1 : 0;
    if (taken != 0) begin
      m_ctr[k][idx]   = (hit != 0) ? ((m_ctr[k][idx] < 3) ? m_ctr[k][idx] + 1 : 3) : 2;
      m_valid[k][idx] = 1;
      m_tag[k][idx]   = pc / 64;
      m_tgt[k][idx]   = tgt;
    end else if (hit != 0 && m_ctr[k][idx] > 0) begin
      m_ctr[k][idx] = m_ctr[k][idx] - 1;
    end
    m_ghr[k] = (m_ghr[k] * 2 + taken) % 16;
    if (m_nb[k] < 65535) m_nb[k]++;
    if (actual != pn && m_nm[k] < 65535) m_nm[k]++;
  endtask

  task automatic check_dut(input int k, input int lpc, input int uv, input int upc, input int ut,
                           input int utgt, input int upn, input logic pt, input logic [15:0] pn,
                           input logic [5:0] pi, input logic mp, input logic [15:0] cp,
                           input logic [15:0] nb, input logic [15:0] nm);
    string p      = (k == 0) ? "m2" : "m3";
    int    actual = (ut != 0) ? utgt : (upc + 1) % 65536;
    int    exp_mp = (uv != 0 && actual != upn) ? 1 : 0;
    check_eq({p, "_pred_taken"}, 32'(pt), 32'(m_taken(k, lpc)));
    check_eq({p, "_pred_next_pc"}, 32'(pn), 32'(m_pnext(k, lpc)));
    check_eq({p, "_pred_index"}, 32'(pi), 32'(m_idx(k, lpc)));
    check_eq({p, "_mispredict"}, 32'(mp), 32'(exp_mp));
    if (exp_mp != 0) check_eq({p, "_correct_pc"}, 32'(cp), 32'(actual));
    check_eq({p, "_num_branch"}, 32'(nb), 32'(m_nb[k]));
    check_eq({p, "_num_branch_miss"}, 32'(nm), 32'(m_nm[k]));
  endtask

  // pred_sel: -1 = fetch-time model prediction, -2 = deliberately wrong, else a literal value.
  task automatic drive_cycle(input logic rst, input logic [15:0] lpc, input logic uv, input logic [15:0] upc,
                             input logic ut, input logic [15:0] utgt, input int pred_sel);
    int pn [2];
    int ui [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      if (pred_sel == -1)      pn[k] = m_pnext(k, upc);
      else if (pred_sel == -2) pn[k] = m_pnext(k, upc) ^ 1;
      else                     pn[k] = pred_sel;
      ui[k] = m_idx(k, upc);
    end
    reset = rst; lookup_pc = lpc; update_valid = uv; update_pc = upc;
    update_taken = ut; update_target = utgt;
    upd_idx2 = 6'(ui[0]); upd_idx3 = 6'(ui[1]);
    upd_pn2 = 16'(pn[0]); upd_pn3 = 16'(pn[1]);
    #1;
    check_dut(0, lpc, uv, upc, ut, utgt, pn[0], pt2, pn2_o, pi2, mp2, cp2, nb2, nm2);
    check_dut(1, lpc, uv, upc, ut, utgt, pn[1], pt3, pn3_o, pi3, mp3, cp3, nb3, nm3);
    s_next[0] = pn2_o; s_next[1] = pn3_o;
    s_idx[0]  = int'(pi2); s_idx[1] = int'(pi3);
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) m_reset(k);
      else if (uv) m_update(k, ui[k], upc, ut, utgt, pn[k]);
    end
  endtask

  initial begin
    reset = 1'b1; lookup_pc = '0; update_valid = 1'b0; update_pc = '0; update_taken = 1'b0;
    update_target = '0; upd_idx2 = '0; upd_idx3 = '0; upd_pn2 = '0; upd_pn3 = '0;
    repeat (2) @(posedge clk);
    m_reset(0); m_reset(1);

    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_reset_next", 32'(s_next[0]), 32'h0011);
    check_eq("tp_reset_nb", 32'(nb2), 32'h0);

    drive_cycle(0, 16'h0010, 1, 16'h0010, 1, 16'h0040, 16'h0011);
    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_first_target", 32'(s_next[0]), 32'h0040);
    check_eq("tp_first_miss", 32'(nm2), 32'h1);

    repeat (4) drive_cycle(0, 16'h0000, 1, 16'h0010, 1, 16'h0040, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0010, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_ctr2_taken", 32'(s_next[0]), 32'h0040);
    drive_cycle(0, 16'h0000, 1, 16'h0010, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_ctr1_not_taken", 32'(s_next[0]), 32'h0011);

    drive_cycle(0, 16'h0050, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_alias", 32'(s_next[0]), 32'h0051);

    drive_cycle(0, 16'h0010, 1, 16'h0010, 1, 16'h0040, -1);
    check_eq("tp_war_old", 32'(s_next[0]), 32'h0011);
    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_war_new", 32'(s_next[0]), 32'h0040);

    drive_cycle(1, 16'h0020, 1, 16'h0020, 1, 16'h0099, -1);
    drive_cycle(0, 16'h0020, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_rst_upd_next", 32'(s_next[0]), 32'h0021);
    check_eq("tp_rst_upd_nb", 32'(nb2), 32'h0);
    drive_cycle(0, 16'h0010, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_rst_empty", 32'(s_next[0]), 32'h0011);

    drive_cycle(0, 16'h0000, 1, 16'h0100, 1, 16'h0200, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0100, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0100, 1, 16'h0200, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0100, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0003, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_gshare_idx", 32'(s_idx[1]), 32'd9);
    check_eq("tp_plain_idx", 32'(s_idx[0]), 32'd3);

    repeat (10) drive_cycle(0, 16'h0003, 1, 16'h0003, 1, 16'h0300, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0003, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0003, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_sat_high", 32'(s_next[0]), 32'h0300);
    repeat (10) drive_cycle(0, 16'h0003, 1, 16'h0003, 0, 16'h0000, -1);
    drive_cycle(0, 16'h0000, 1, 16'h0003, 1, 16'h0300, -1);
    drive_cycle(0, 16'h0003, 0, 16'h0000, 0, 16'h0000, -1);
    check_eq("tp_sat_low", 32'(s_next[0]), 32'h0004);

    drive_cycle(0, 16'hFFFF, 1, 16'hFFFF, 0, 16'h0000, 16'h0000);
    check_eq("tp_wrap", 32'(s_next[0]), 32'h0000);

    for (int n = 0; n < 400; n++) begin
      logic [15:0] lpc, upc;
      lpc = (n % 37 == 0) ? 16'hFFFF : 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      upc = 16'(($urandom_range(0, 3) << 6) | $urandom_range(0, 7));
      drive_cycle(n == 200, lpc, $urandom_range(0, 3) != 0, upc, 1'($urandom_range(0, 1)),
                  16'($urandom), ($urandom_range(0, 4) == 0) ? -2 : -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
